// File: rtl/snow64_main_mem_requester.sv
// Main-memory requester: arbitrates instruction-fetch and data ports onto one synchronous single-port memory.
// Optional macro SNOW64_MAIN_MEM_REQ_ROUND_ROBIN_EN switches fixed D-priority to round-robin arbitration.

package PkgSnow64MainMem;
    localparam int MSB_POS__MEM_ADDRESS = 31;
    localparam int MSB_POS__DATA_INOUT  = 63;
endpackage

module snow64_main_mem_requester #(
    parameter int ADDR_WIDTH = PkgSnow64MainMem::MSB_POS__MEM_ADDRESS + 1,
    parameter int DATA_WIDTH = PkgSnow64MainMem::MSB_POS__DATA_INOUT + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_req_ready,
    output logic                  i_resp_valid,

    input  logic                  d_req_valid,
    input  logic                  d_req_wr,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    output logic                  d_req_ready,
    output logic                  d_resp_valid,

    output logic [DATA_WIDTH-1:0] resp_data,

    output logic                  mem_req_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;

    logic [1:0] state;
    logic       owner_d;
    logic       idle;
    logic       grant_d;
    logic       grant_i;
    logic       accept_d;
    logic       accept_i;

    assign idle = (state == ST_IDLE);

`ifdef SNOW64_MAIN_MEM_REQ_ROUND_ROBIN_EN
    // rr_favor_i: I wins the next contention (it was not granted last).
    logic rr_favor_i;

    always_comb begin
        grant_d = d_req_valid && !(i_req_valid && rr_favor_i);
        grant_i = i_req_valid && !(d_req_valid && !rr_favor_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_favor_i <= 1'b0;
        end else if (accept_d) begin
            rr_favor_i <= 1'b1;
        end else if (accept_i) begin
            rr_favor_i <= 1'b0;
        end
    end
`else
    always_comb begin
        grant_d = d_req_valid;
        grant_i = i_req_valid && !d_req_valid;
    end
`endif

    assign d_req_ready = idle && grant_d;
    assign i_req_ready = idle && grant_i;
    assign accept_d    = d_req_valid && d_req_ready;
    assign accept_i    = i_req_valid && i_req_ready;

    // mem_req_wr doubles as the "current transaction is a write" flag in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            owner_d      <= 1'b0;
            mem_req_wr   <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            resp_data    <= '0;
            i_resp_valid <= 1'b0;
            d_resp_valid <= 1'b0;
        end else begin
            i_resp_valid <= 1'b0;
            d_resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_d) begin
                        mem_addr   <= d_req_addr;
                        mem_wdata  <= d_req_wdata;
                        mem_req_wr <= d_req_wr;
                        owner_d    <= 1'b1;
                        state      <= ST_ISSUE;
                    end else if (accept_i) begin
                        mem_addr   <= i_req_addr;
                        mem_req_wr <= 1'b0;
                        owner_d    <= 1'b0;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_req_wr <= 1'b0;
                    if (mem_req_wr) begin
                        d_resp_valid <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    resp_data <= mem_rdata;
                    if (owner_d) d_resp_valid <= 1'b1;
                    else         i_resp_valid <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    mem_req_wr <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/snow64_main_mem_requester.md
SNOW64_MAIN_MEM_REQUESTER -- requirements
Module: snow64_main_mem_requester

Interface
- REQ-001: The block SHALL have parameter ADDR_WIDTH, default PkgSnow64MainMem::MSB_POS__MEM_ADDRESS+1, main-memory word-address width.
- REQ-002: The block SHALL have parameter DATA_WIDTH, default PkgSnow64MainMem::MSB_POS__DATA_INOUT+1, main-memory word width.
- REQ-003: The block SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
- REQ-004: The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
- REQ-005: The block SHALL have port i_req_valid, input, 1, instruction-fetch read request.
- REQ-006: The block SHALL have port i_req_addr, input, ADDR_WIDTH, instruction-fetch word address.
- REQ-007: The block SHALL have port i_req_ready, output, 1, instruction-fetch request accepted this cycle.
- REQ-008: The block SHALL have port i_resp_valid, output, 1, one-cycle pulse; resp_data holds the fetch word.
- REQ-009: The block SHALL have port d_req_valid, input, 1, data request.
- REQ-010: The block SHALL have port d_req_wr, input, 1, data request is a write (1) or read (0).
- REQ-011: The block SHALL have port d_req_addr, input, ADDR_WIDTH, data word address.
- REQ-012: The block SHALL have port d_req_wdata, input, DATA_WIDTH, write data.
- REQ-013: The block SHALL have port d_req_ready, output, 1, data request accepted this cycle.
- REQ-014: The block SHALL have port d_resp_valid, output, 1, one-cycle pulse; read data is on resp_data, or write is complete.
- REQ-015: The block SHALL have port resp_data, output, DATA_WIDTH, registered read data shared by both ports.
- REQ-016: The block SHALL have ports mem_req_wr (output, 1), mem_addr (output, ADDR_WIDTH), mem_wdata (output, DATA_WIDTH) and mem_rdata (input, DATA_WIDTH); these connect to the main memory in_req_wr/in_addr/in_data/out_data.

Function
- REQ-017: The main memory SHALL be treated as a synchronous single port: a write is committed at the edge where mem_req_wr=1, and mem_rdata reflects mem_addr one cycle after that address is presented.
- REQ-018: The FSM SHALL have states IDLE, ISSUE, and RD_WAIT; x_req_ready SHALL be asserted only in IDLE and only for the granted port.
- REQ-019: Acceptance SHALL occur on the edge where x_req_valid && x_req_ready; at that edge the block registers mem_addr, mem_wdata, mem_req_wr (1 only for a data write), and the owner, then enters ISSUE.
- REQ-020: After ISSUE, a write SHALL return to IDLE, deassert mem_req_wr, and pulse d_resp_valid for exactly one cycle.
- REQ-021: After ISSUE, a read SHALL enter RD_WAIT; at the edge leaving RD_WAIT, mem_rdata is captured into resp_data, the owner's resp_valid pulses for one cycle, and the state returns to IDLE.
- REQ-022: Latency SHALL be as follows: resp_valid is high in the 2nd cycle after acceptance for a write and in the 3rd cycle for a read; a new request may be accepted in that same cycle.
- REQ-023: mem_req_wr SHALL be high for exactly one cycle per write and never high outside ISSUE.
- REQ-024: mem_addr and mem_wdata SHALL hold their last values while IDLE; resp_data SHALL hold its value until the next read capture.
- REQ-025: Requests SHALL NOT be reordered; at most one transaction SHALL be outstanding.
- REQ-026: The default arbitration SHALL be fixed priority: when both valids are high in IDLE, D is granted; I is granted only when d_req_valid=0.
- REQ-027: Clients SHALL hold valid/addr/data stable until accepted; an inbound valid dropped before acceptance SHALL be ignored.

Reset
- REQ-028: When rst_n=0, the block SHALL asynchronously force state=IDLE, mem_req_wr=0, mem_addr=0, mem_wdata=0, resp_data=0, i_resp_valid=0, d_resp_valid=0, and the round-robin pointer to D.
- REQ-029: Reset mid-transaction SHALL abort the transaction: there SHALL be no resp_valid for it, and mem_req_wr SHALL fall immediately.
- REQ-030: The block SHALL accept its first request in the first cycle after rst_n rises.

Configuration
- REQ-031: With SNOW64_MAIN_MEM_REQ_ROUND_ROBIN_EN defined, a simultaneous I/D contention SHALL be granted to the port not granted last, and the pointer updates on each acceptance.
- REQ-032: With SNOW64_MAIN_MEM_REQ_ROUND_ROBIN_EN undefined, the fixed priority of REQ-026 SHALL apply and the pointer SHALL be absent.

Verification
- REQ-033: D write addr 0x10, wdata 0xA5..A5 -> mem_req_wr high exactly one cycle with mem_addr=0x10; d_resp_valid in the 2nd cycle after acceptance.
- REQ-034: After REQ-033, D read addr 0x10 -> d_resp_valid in the 3rd cycle after acceptance, resp_data=0xA5..A5, i_resp_valid=0.
- REQ-035: I and D valid in the same cycle (I addr 0x0, D addr 0x1000), fixed priority -> D served first, I accepted in D's response cycle; with the macro, a second contention grants I first.
- REQ-036: rst_n pulsed low during RD_WAIT -> no resp_valid, mem_req_wr=0, resp_data=0; a new I read of 0x0 completes normally after release.
- REQ-037: Back-to-back I reads 0x0, 0x1, 0x2 with valid held high -> one acceptance every 3 cycles, in-order resp_data matching memory contents.
